cga_vga_output: RTL and testbench

//   VGA output stage, directly downstream of the CGA scan doubler.
//   - Consumes doubled 4-bit RGBI video and doubled hsync; takes CGA vsync from the CRTC.
//   - Regenerates a 2-line VGA vsync aligned to doubled lines and computes H/V blanking.
//   - Maps RGBI to 2-bit-per-channel R/G/B with optional brown fix, and drives the VGA pins.

---
 rtl/cga_vga_output.sv | 136 +++++++++++++
 tb/tb_cga_vga_output.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cga_vga_output.sv
// VGA output stage behind the CGA scan doubler: regenerates a line-aligned VGA vsync,
// computes the active window and maps RGBI onto 2-bit-per-channel VGA colour.
module cga_vga_output #(
  parameter logic [9:0] H_START   = 10'd32,
  parameter logic [9:0] H_ACTIVE  = 10'd720,
  parameter logic [9:0] V_START   = 10'd76,
  parameter logic [9:0] V_ACTIVE  = 10'd400,
  parameter logic [9:0] VS_LINES  = 10'd2,
  parameter logic       HS_POS    = 1'b0,
  parameter logic       VS_POS    = 1'b0,
  parameter logic       BROWN_FIX = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] dbl_video,
  input  logic       dbl_hsync,
  input  logic       cga_vsync,
  output logic [1:0] vga_r,
  output logic [1:0] vga_g,
  output logic [1:0] vga_b,
  output logic       vga_hsync,
  output logic       vga_vsync,
  output logic       blank
);

  // Window limits are formed in 11 bits so start + length cannot overflow.
  localparam logic [10:0] H_BEGIN = {1'b0, H_START};
  localparam logic [10:0] H_END   = {1'b0, H_START} + {1'b0, H_ACTIVE};
  localparam logic [10:0] V_BEGIN = {1'b0, V_START};
  localparam logic [10:0] V_END   = {1'b0, V_START} + {1'b0, V_ACTIVE};
  localparam logic [9:0]  CNT_MAX = 10'h3FF;

  logic [3:0] video_s1;
  logic       hsync_s1;
  logic       vsync_s1;
  logic       hsync_d;
  logic       vsync_d;

  logic [9:0] hcount;
  logic [9:0] vline;
  logic       arm;

  logic       hs_rise;
  logic       hs_fall;
  logic       vs_rise;
  logic       h_act;
  logic       v_act;
  logic       vs_on;
  logic       blank_next;
  logic [1:0] r_map;
  logic [1:0] g_map;
  logic [1:0] b_map;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      video_s1 <= 4'h0;
      hsync_s1 <= 1'b0;
      vsync_s1 <= 1'b0;
      hsync_d  <= 1'b0;
      vsync_d  <= 1'b0;
    end else begin
      video_s1 <= dbl_video;
      hsync_s1 <= dbl_hsync;
      vsync_s1 <= cga_vsync;
      hsync_d  <= hsync_s1;
      vsync_d  <= vsync_s1;
    end
  end

  assign hs_rise = hsync_s1 & ~hsync_d;
  assign hs_fall = ~hsync_s1 & hsync_d;
  assign vs_rise = vsync_s1 & ~vsync_d;

  // Saturating counter: a missing hsync leaves the line blanked instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcount <= CNT_MAX;
    end else if (hs_fall) begin
      hcount <= 10'd0;
    end else if (hcount != CNT_MAX) begin
      hcount <= hcount + 10'd1;
    end
  end

  // A vsync rise only arms realignment; the line count restarts on the next hsync rise,
  // including one arriving in the same cycle as the vsync rise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vline <= CNT_MAX;
      arm   <= 1'b0;
    end else if (hs_rise) begin
      if (arm || vs_rise) begin
        vline <= 10'd0;
      end else if (vline != CNT_MAX) begin
        vline <= vline + 10'd1;
      end
      arm <= 1'b0;
    end else if (vs_rise) begin
      arm <= 1'b1;
    end
  end

  assign h_act      = ({1'b0, hcount} >= H_BEGIN) && ({1'b0, hcount} < H_END);
  assign v_act      = ({1'b0, vline} >= V_BEGIN) && ({1'b0, vline} < V_END);
  assign vs_on      = (vline < VS_LINES);
  assign blank_next = ~(h_act & v_act);

  // Dark yellow is shown as brown by halving its green component.
  always_comb begin
    r_map = {video_s1[3], video_s1[0]};
    g_map = {video_s1[2], video_s1[0]};
    b_map = {video_s1[1], video_s1[0]};
    if (BROWN_FIX && (video_s1 == 4'b1100)) begin
      g_map = 2'b01;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vga_r     <= 2'b00;
      vga_g     <= 2'b00;
      vga_b     <= 2'b00;
      blank     <= 1'b1;
      vga_hsync <= ~HS_POS;
      vga_vsync <= ~VS_POS;
    end else begin
      vga_r     <= blank_next ? 2'b00 : r_map;
      vga_g     <= blank_next ? 2'b00 : g_map;
      vga_b     <= blank_next ? 2'b00 : b_map;
      blank     <= blank_next;
      vga_hsync <= hsync_s1 ^ ~HS_POS;
      vga_vsync <= vs_on ^ ~VS_POS;
    end
  end

endmodule

// File: tb/tb_cga_vga_output.sv
// Directed bench for cga_vga_output: default-timing instance (V_START shortened so the
// active window is reachable quickly), a no-brown-fix twin, and a short-line instance.
`timescale 1ns/1ps
module tb_cga_vga_output;

  localparam int LL = 912;
  localparam int SL = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] dbl_video = 4'h0;
  logic       dbl_hsync = 1'b0;
  logic       cga_vsync = 1'b0;

  logic [1:0] a_r, a_g, a_b;
  logic       a_hs, a_vs, a_bl;
  logic [1:0] n_r, n_g, n_b;
  logic       n_hs, n_vs, n_bl;
  logic [1:0] v_r, v_g, v_b;
  logic       v_hs, v_vs, v_bl;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cga_vga_output #(.V_START(10'd2)) u_dut (
    .clk(clk), .reset(reset), .dbl_video(dbl_video), .dbl_hsync(dbl_hsync),
    .cga_vsync(cga_vsync), .vga_r(a_r), .vga_g(a_g), .vga_b(a_b),
    .vga_hsync(a_hs), .vga_vsync(a_vs), .blank(a_bl));

  cga_vga_output #(.V_START(10'd2), .BROWN_FIX(1'b0)) u_nofix (
    .clk(clk), .reset(reset), .dbl_video(dbl_video), .dbl_hsync(dbl_hsync),
    .cga_vsync(cga_vsync), .vga_r(n_r), .vga_g(n_g), .vga_b(n_b),
    .vga_hsync(n_hs), .vga_vsync(n_vs), .blank(n_bl));

  cga_vga_output #(.H_START(10'd4), .H_ACTIVE(10'd8)) u_vert (
    .clk(clk), .reset(reset), .dbl_video(dbl_video), .dbl_hsync(dbl_hsync),
    .cga_vsync(cga_vsync), .vga_r(v_r), .vga_g(v_g), .vga_b(v_b),
    .vga_hsync(v_hs), .vga_vsync(v_vs), .blank(v_bl));

  // Expected colour: {r, g, b}, each channel {colour bit, intensity}.
  function automatic logic [5:0] map_rgb(input logic [3:0] v, input logic fix);
    logic [1:0] g;
    g = (fix && v == 4'b1100) ? 2'b01 : {v[2], v[0]};
    return {v[3], v[0], g, v[1], v[0]};
  endfunction

  // Applies inputs for one cycle and returns at that cycle's falling edge, where the
  // outputs reflect the inputs applied two calls earlier.
  task automatic drive(input logic hs, input logic vs, input logic [3:0] vid);
    @(posedge clk); #1;
    dbl_hsync = hs;
    cga_vsync = vs;
    dbl_video = vid;
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if ({a_bl, a_hs, a_vs, a_r, a_g, a_b} !== 9'b111_000000) begin fails++;
      $display("FAIL reset_dut: got %b expected %b", {a_bl, a_hs, a_vs, a_r, a_g, a_b}, 9'b111_000000); end
    tests++; if ({n_bl, n_hs, n_vs, n_r, n_g, n_b} !== 9'b111_000000) begin fails++;
      $display("FAIL reset_nofix: got %b expected %b", {n_bl, n_hs, n_vs, n_r, n_g, n_b}, 9'b111_000000); end
    tests++; if ({v_bl, v_hs, v_vs, v_r, v_g, v_b} !== 9'b111_000000) begin fails++;
      $display("FAIL reset_vert: got %b expected %b", {v_bl, v_hs, v_vs, v_r, v_g, v_b}, 9'b111_000000); end
    @(posedge clk); #1 reset = 1'b0;
  endtask

  // Without any cga_vsync since reset the display must stay blanked with vsync idle.
  task automatic test_post_reset_blank;
    int act = 0;
    int vlow = 0;
    for (int j = 0; j < 4; j++)
      for (int p = 0; p < LL; p++) begin
        drive(p >= 720 && p < 880, 1'b0, 4'hF);
        if (a_bl == 1'b0) act++;
        if (a_vs == 1'b0) vlow++;
      end
    tests++; if (act !== 0) begin fails++; $display("FAIL post_reset_active: got %0d expected 0", act); end
    tests++; if (vlow !== 0) begin fails++; $display("FAIL post_reset_vsync: got %0d expected 0", vlow); end
  endtask

  // 912-clock lines, hsync high at 720..879, vsync pulse in line 0 (realign at its hsync
  // rise). hcount=0 lines up with the input one clock after the hsync fall, so active
  // inputs are positions 1..720 of the following line; line 5 has no hsync for 1800 clocks.
  task automatic test_horizontal;
    int j1 = -1, p1 = 0, j2 = -1, p2 = 0, len;
    logic [3:0] v1 = 4'h0, v2 = 4'h0, vid;
    logic exp_act;
    int act3 = 0, first3 = -1, last3 = -1, act12 = 0, act5 = 0, sat_act = 0;
    int hs_low3 = 0, hs_first3 = -1, vs_low = 0, vs_first = -1, vs_last = -1;
    int map_err = 0, nofix_err = 0;
    logic [5:0] rgb_b = 6'h0, rgb_c = 6'h0, rgb_c_nofix = 6'h0;
    for (int j = 0; j < 7; j++) begin
      len = (j == 5) ? 1800 : ((j == 6) ? 2 : LL);
      for (int p = 0; p < len; p++) begin
        vid = (j >= 3) ? 4'(p) : 4'hF;
        drive((j < 5) && p >= 720 && p < 880, (j == 0) && p < 10, vid);
        if (j2 >= 0) begin
          exp_act = (j2 >= 3) && (j2 <= 5) && (p2 >= 1) && (p2 <= 720);
          if (!a_bl) begin
            if (j2 == 3) begin act3++; if (first3 < 0) first3 = p2; last3 = p2; end
            if (j2 == 1 || j2 == 2) act12++;
            if (j2 == 5 && p2 <= 720) act5++;
            if (j2 == 5 && p2 > 720) sat_act++;
          end
          if (j2 == 3 && !a_hs) begin hs_low3++; if (hs_first3 < 0) hs_first3 = p2; end
          if (!a_vs) begin vs_low++; if (vs_first < 0) vs_first = j2 * 4096 + p2; vs_last = j2 * 4096 + p2; end
          if ({a_r, a_g, a_b} !== (exp_act ? map_rgb(v2, 1'b1) : 6'd0)) map_err++;
          if ({n_r, n_g, n_b} !== (exp_act ? map_rgb(v2, 1'b0) : 6'd0) || n_bl !== !exp_act) nofix_err++;
          if (j2 == 3 && p2 == 11) rgb_b = {a_r, a_g, a_b};
          if (j2 == 3 && p2 == 12) begin rgb_c = {a_r, a_g, a_b}; rgb_c_nofix = {n_r, n_g, n_b}; end
        end
        j2 = j1; p2 = p1; v2 = v1;
        j1 = j;  p1 = p;  v1 = vid;
      end
    end
    tests++; if (act3 !== 720) begin fails++; $display("FAIL h_active_len: got %0d expected 720", act3); end
    tests++; if (first3 !== 1) begin fails++; $display("FAIL h_first_active: got %0d expected 1", first3); end
    tests++; if (last3 !== 720) begin fails++; $display("FAIL h_last_active: got %0d expected 720", last3); end
    tests++; if (act12 !== 0) begin fails++; $display("FAIL v_before_start: got %0d expected 0", act12); end
    tests++; if (act5 !== 720) begin fails++; $display("FAIL h_long_line_active: got %0d expected 720", act5); end
    tests++; if (sat_act !== 0) begin fails++; $display("FAIL hcount_saturate: got %0d expected 0", sat_act); end
    tests++; if (hs_low3 !== 160) begin fails++; $display("FAIL hsync_width: got %0d expected 160", hs_low3); end
    tests++; if (hs_first3 !== 720) begin fails++; $display("FAIL hsync_latency: got %0d expected 720", hs_first3); end
    tests++; if (vs_low !== 1824) begin fails++; $display("FAIL vsync_width: got %0d expected 1824", vs_low); end
    tests++; if (vs_first !== 721) begin fails++; $display("FAIL vsync_start: got %0d expected 721", vs_first); end
    tests++; if (vs_last !== 2 * 4096 + 720) begin fails++; $display("FAIL vsync_end: got %0d expected %0d", vs_last, 2 * 4096 + 720); end
    tests++; if (map_err !== 0) begin fails++; $display("FAIL rgb_map: got %0d errors expected 0", map_err); end
    tests++; if (nofix_err !== 0) begin fails++; $display("FAIL rgb_map_nofix: got %0d errors expected 0", nofix_err); end
    tests++; if (rgb_b !== 6'b11_01_11) begin fails++; $display("FAIL latency_1011: got %b expected %b", rgb_b, 6'b110111); end
    tests++; if (rgb_c !== 6'b10_01_00) begin fails++; $display("FAIL brown_fix: got %b expected %b", rgb_c, 6'b100100); end
    tests++; if (rgb_c_nofix !== 6'b10_10_00) begin fails++; $display("FAIL brown_nofix: got %b expected %b", rgb_c_nofix, 6'b101000); end
  endtask

  task automatic test_reset_mid;
    int act = 0;
    int vlow = 0;
    for (int p = 0; p < LL; p++) drive(p >= 720 && p < 880, p < 10, 4'hF);
    for (int p = 0; p <= 800; p++) drive(p >= 720 && p < 880, 1'b0, 4'hF);
    tests++; if ({a_hs, a_vs} !== 2'b00) begin fails++; $display("FAIL pre_reset_syncs: got %b expected 00", {a_hs, a_vs}); end
    reset = 1'b1; #2;
    tests++; if ({a_bl, a_hs, a_vs, a_r, a_g, a_b} !== 9'b111_000000) begin fails++;
      $display("FAIL reset_mid_sync: got %b expected %b", {a_bl, a_hs, a_vs, a_r, a_g, a_b}, 9'b111_000000); end
    @(posedge clk); #1 reset = 1'b0;
    for (int p = 801; p < LL; p++) begin
      drive(p >= 720 && p < 880, 1'b0, 4'hF);
      if (!a_bl) act++;
      if (!a_vs) vlow++;
    end
    for (int j = 0; j < 3; j++)
      for (int p = 0; p < LL; p++) begin
        drive(p >= 720 && p < 880, 1'b0, 4'hF);
        if (!a_bl) act++;
        if (!a_vs) vlow++;
      end
    tests++; if (act !== 0) begin fails++; $display("FAIL reset_frame_blank: got %0d expected 0", act); end
    tests++; if (vlow !== 0) begin fails++; $display("FAIL reset_frame_vsync: got %0d expected 0", vlow); end
    for (int j = 0; j < 3; j++)
      for (int p = 0; p < LL; p++) drive(p >= 720 && p < 880, (j == 0) && p < 10, 4'hF);
    for (int p = 0; p <= 100; p++) drive(p >= 720 && p < 880, 1'b0, 4'hF);
    tests++; if ({a_bl, a_r} !== 3'b011) begin fails++; $display("FAIL pre_reset_active: got %b expected 011", {a_bl, a_r}); end
    reset = 1'b1; #2;
    tests++; if ({a_bl, a_r, a_g, a_b} !== 7'b1_000000) begin fails++;
      $display("FAIL reset_mid_active: got %b expected %b", {a_bl, a_r, a_g, a_b}, 7'b1000000); end
    @(posedge clk); #1 reset = 1'b0;
  endtask

  // 20-clock lines, hsync high at 12..15; u_vert is active at positions 1..8 of line j
  // when j-1 lies in 76..475 after realignment in line 0.
  task automatic test_vertical;
    int j1 = -1, p1 = 0, j2 = -1, p2 = 0, len;
    int act = 0, first = -1, last = -1, vs_low = 0, vs_first = -1, vs_last = -1, rgb_err = 0;
    for (int j = 0; j < 531; j++) begin
      len = (j == 530) ? 2 : SL;
      for (int p = 0; p < len; p++) begin
        drive((j < 530) && p >= 12 && p < 16, (j == 0) && p < 4, 4'hF);
        if (j2 >= 0) begin
          if (!v_bl) begin act++; if (first < 0) first = j2 * 4096 + p2; last = j2 * 4096 + p2; end
          if (!v_vs) begin vs_low++; if (vs_first < 0) vs_first = j2 * 4096 + p2; vs_last = j2 * 4096 + p2; end
          if ({v_r, v_g, v_b} !== (v_bl ? 6'd0 : 6'b111111)) rgb_err++;
        end
        j2 = j1; p2 = p1;
        j1 = j;  p1 = p;
      end
    end
    tests++; if (act !== 3200) begin fails++; $display("FAIL v_active_pixels: got %0d expected 3200", act); end
    tests++; if (first !== 77 * 4096 + 1) begin fails++; $display("FAIL v_first_active: got %0d expected %0d", first, 77 * 4096 + 1); end
    tests++; if (last !== 476 * 4096 + 8) begin fails++; $display("FAIL v_last_active: got %0d expected %0d", last, 476 * 4096 + 8); end
    tests++; if (vs_low !== 40) begin fails++; $display("FAIL v_vsync_width: got %0d expected 40", vs_low); end
    tests++; if (vs_first !== 13) begin fails++; $display("FAIL v_vsync_start: got %0d expected 13", vs_first); end
    tests++; if (vs_last !== 2 * 4096 + 12) begin fails++; $display("FAIL v_vsync_end: got %0d expected %0d", vs_last, 2 * 4096 + 12); end
    tests++; if (rgb_err !== 0) begin fails++; $display("FAIL v_rgb_blanking: got %0d errors expected 0", rgb_err); end
  endtask

  // cga_vsync rises in the very cycle hsync rises: realign on that edge, arm left clear.
  task automatic test_coincident;
    int j1 = -1, p1 = 0, j2 = -1, p2 = 0, len;
    int vs_low = 0, vs_first = -1, vs_last = -1;
    for (int j = 0; j < 5; j++) begin
      len = (j == 4) ? 2 : SL;
      for (int p = 0; p < len; p++) begin
        drive((j < 4) && p >= 12 && p < 16, (j == 0) && p >= 12 && p < 16, 4'hF);
        if (j2 >= 0 && !v_vs) begin vs_low++; if (vs_first < 0) vs_first = j2 * 4096 + p2; vs_last = j2 * 4096 + p2; end
        j2 = j1; p2 = p1;
        j1 = j;  p1 = p;
      end
    end
    tests++; if (vs_low !== 40) begin fails++; $display("FAIL coincident_width: got %0d expected 40", vs_low); end
    tests++; if (vs_first !== 13) begin fails++; $display("FAIL coincident_start: got %0d expected 13", vs_first); end
    tests++; if (vs_last !== 2 * 4096 + 12) begin fails++; $display("FAIL coincident_end: got %0d expected %0d", vs_last, 2 * 4096 + 12); end
  endtask

  // Four vsync rises before one hsync rise must realign exactly once.
  task automatic test_repeated_vsync;
    int j1 = -1, p1 = 0, j2 = -1, p2 = 0, len;
    int vs_low = 0, vs_first = -1, vs_last = -1;
    for (int j = 0; j < 5; j++) begin
      len = (j == 4) ? 2 : SL;
      for (int p = 0; p < len; p++) begin
        drive((j < 4) && p >= 12 && p < 16, (j == 0) && p < 8 && (p % 2 == 0), 4'hF);
        if (j2 >= 0 && !v_vs) begin vs_low++; if (vs_first < 0) vs_first = j2 * 4096 + p2; vs_last = j2 * 4096 + p2; end
        j2 = j1; p2 = p1;
        j1 = j;  p1 = p;
      end
    end
    tests++; if (vs_low !== 40) begin fails++; $display("FAIL repeated_width: got %0d expected 40", vs_low); end
    tests++; if (vs_first !== 13) begin fails++; $display("FAIL repeated_start: got %0d expected 13", vs_first); end
    tests++; if (vs_last !== 2 * 4096 + 12) begin fails++; $display("FAIL repeated_end: got %0d expected %0d", vs_last, 2 * 4096 + 12); end
  endtask

  // 1200 lines with no cga_vsync: vline (3 on entry) passes the window once, then holds 3FF.
  task automatic test_no_vsync;
    int j1 = -1, j2 = -1, len;
    int act = 0, act_late = 0, vs_low = 0;
    for (int j = 0; j < 1201; j++) begin
      len = (j == 1200) ? 2 : SL;
      for (int p = 0; p < len; p++) begin
        drive((j < 1200) && p >= 12 && p < 16, 1'b0, 4'hF);
        if (j2 >= 0) begin
          if (!v_bl) begin act++; if (j2 >= 500) act_late++; end
          if (!v_vs) vs_low++;
        end
        j2 = j1;
        j1 = j;
      end
    end
    tests++; if (act !== 3200) begin fails++; $display("FAIL novs_window: got %0d expected 3200", act); end
    tests++; if (act_late !== 0) begin fails++; $display("FAIL novs_saturate_blank: got %0d expected 0", act_late); end
    tests++; if (vs_low !== 0) begin fails++; $display("FAIL novs_vsync: got %0d expected 0", vs_low); end
    tests++; if ({v_bl, v_vs} !== 2'b11) begin fails++; $display("FAIL novs_final: got %b expected 11", {v_bl, v_vs}); end
  endtask

  initial begin
    test_reset();
    test_post_reset_blank();
    test_horizontal();
    test_reset_mid();
    test_vertical();
    test_coincident();
    test_repeated_vsync();
    test_no_vsync();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
